// File: rtl/code_queue_pkg.sv
// code_queue_pkg: shared types and constants for the instruction prefetch queue.
package code_queue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } cq_state_t;

  // Dwords presented to the decoder in the code window.
  localparam int CQ_WIN_DWORDS = 4;
  // Longest instruction the decoder can retire in one consume.
  localparam int CQ_MAX_ILEN   = 15;

  function automatic logic [31:0] cq_dword_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/code_queue_ram.sv
// code_queue_ram: DEPTH x 32 circular dword store with one write port and a
// window of CQ_WIN_DWORDS contiguous reads starting at the head pointer.
module code_queue_ram
  import code_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          we,
  input  logic [$clog2(DEPTH)-1:0]      waddr,
  input  logic [31:0]                   wdata,
  input  logic [$clog2(DEPTH)-1:0]      head,
  output logic [32*CQ_WIN_DWORDS-1:0]   rdata
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0] r_mem [DEPTH];

  // Storage: cleared on reset so the window reads zero until filled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Window read: pointer arithmetic wraps naturally because DEPTH is a power of 2.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < CQ_WIN_DWORDS; k++) begin
      rdata[32*k +: 32] = r_mem[head + PW'(k)];
    end
  end

endmodule

// File: rtl/code_queue.sv
// code_queue: instruction prefetch queue and fetch sequencer for the decoder.
// Optional feature macro: CODE_QUEUE_STATS_EN adds the stall_cnt output.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no fetch address yet; waits for the first flush
// RUN   | fetching into the queue and serving the decoder window
// DRAIN | flushed while a request was outstanding; waits for its ack and
//       | throws the data away before restarting at the latched address
module code_queue
  import code_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic [31:0]  flush_addr,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [31:0]  mem_data,
  output logic [127:0] codebuf,
  output logic [1:0]   align,
  output logic [31:0]  code_addr,
  output logic         code_valid,
  input  logic         consume,
  input  logic [3:0]   consume_len
`ifdef CODE_QUEUE_STATS_EN
  ,
  output logic [31:0]  stall_cnt
`endif
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int SUM_W = $clog2(3 + CQ_MAX_ILEN + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] WIN  = CW'(CQ_WIN_DWORDS);

  cq_state_t        r_state;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [1:0]       r_align;
  logic [31:0]      r_code_addr;
  logic [31:0]      r_fetch_addr;
  logic [31:0]      r_drain_addr;
  logic             r_mem_req;
  logic             r_code_valid;

  logic             w_push;
  logic             w_consume_ok;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-3:0] w_pop;
  logic [CW-1:0]    w_count_next;
  logic [31:0]      w_flush_dw;

  // Push/pop decisions for this cycle; flush wins over both.
  always_comb begin
    w_flush_dw   = cq_dword_align(flush_addr);
    w_push       = (r_state == RUN) && r_mem_req && mem_ack && !flush;
    w_consume_ok = consume && r_code_valid && !flush && (consume_len != 4'd0);
    w_sum        = SUM_W'(r_align) + SUM_W'(consume_len);
    w_pop        = w_consume_ok ? w_sum[SUM_W-1:2] : '0;
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  end

  // Sequencer: fetch state, queue pointers and all decoder-facing registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_align      <= '0;
      r_code_addr  <= '0;
      r_fetch_addr <= '0;
      r_drain_addr <= '0;
      r_mem_req    <= 1'b0;
      r_code_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (flush) begin
            r_state      <= RUN;
            r_fetch_addr <= w_flush_dw;
            r_mem_req    <= 1'b1;
          end
        end
        RUN: begin
          if (flush) begin
            if (r_mem_req && !mem_ack) begin
              // Request in flight: memory still owns mem_addr until it acks.
              r_state      <= DRAIN;
              r_drain_addr <= w_flush_dw;
            end else begin
              r_fetch_addr <= w_flush_dw;
              r_mem_req    <= 1'b1;
            end
          end else begin
            if (w_push) begin
              r_tail       <= r_tail + PW'(1);
              r_fetch_addr <= r_fetch_addr + 32'd4;
            end
            if (w_consume_ok) begin
              r_head      <= r_head + PW'(w_pop);
              r_align     <= w_sum[1:0];
              r_code_addr <= r_code_addr + 32'(consume_len);
            end
            r_count      <= w_count_next;
            r_code_valid <= (w_count_next >= WIN);
            // After an ack the request line rests for one cycle.
            if (r_mem_req) begin
              r_mem_req <= !mem_ack;
            end else begin
              r_mem_req <= (w_count_next < FULL);
            end
          end
        end
        DRAIN: begin
          if (flush) begin
            r_drain_addr <= w_flush_dw;
          end
          if (mem_ack) begin
            r_state      <= RUN;
            r_mem_req    <= 1'b1;
            r_fetch_addr <= flush ? w_flush_dw : r_drain_addr;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase

      if (flush) begin
        r_count      <= '0;
        r_head       <= '0;
        r_tail       <= '0;
        r_code_valid <= 1'b0;
        r_align      <= flush_addr[1:0];
        r_code_addr  <= flush_addr;
      end
    end
  end

  code_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (w_push),
    .waddr   (r_tail),
    .wdata   (mem_data),
    .head    (r_head),
    .rdata   (codebuf)
  );

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_fetch_addr;
  assign code_valid = r_code_valid;
  assign align      = r_align;
  assign code_addr  = r_code_addr;

`ifdef CODE_QUEUE_STATS_EN
  logic [31:0] r_stall_cnt;

  // Cycles spent fetching without a full window for the decoder; saturating.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == RUN) && !r_code_valid && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_code_queue.sv
// tb_code_queue: directed and randomized bench for code_queue with a
// queue-of-dwords reference model.
module tb_code_queue;

  localparam int DEPTH = 8;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         flush;
  logic [31:0]  flush_addr;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_data;
  logic [127:0] codebuf;
  logic [1:0]   align;
  logic [31:0]  code_addr;
  logic         code_valid;
  logic         consume;
  logic [3:0]   consume_len;
`ifdef CODE_QUEUE_STATS_EN
  logic [31:0]  stall_cnt;
`endif

  code_queue #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .flush_addr  (flush_addr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .codebuf     (codebuf),
    .align       (align),
    .code_addr   (code_addr),
    .code_valid  (code_valid),
    .consume     (consume),
    .consume_len (consume_len)
`ifdef CODE_QUEUE_STATS_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int policy = 0;   // 0: never ack, 1: ack every request, 2: random

  // Reference model: mode 0 idle, 1 run, 2 drain; queue holds fetched words.
  int          m_mode;
  logic        m_req;
  logic [31:0] m_fetch;
  logic [31:0] m_drain;
  logic [31:0] m_code_addr;
  logic [31:0] m_q[$];
  logic [31:0] m_stall;
  logic [31:0] acked[$];

  function automatic logic [7:0] bval(input logic [31:0] x);
    return x[7:0] ^ x[23:16] ^ {x[11:8], 4'h0};
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {bval(a + 32'd3), bval(a + 32'd2), bval(a + 32'd1), bval(a)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode      = 0;
    m_req       = 1'b0;
    m_fetch     = '0;
    m_drain     = '0;
    m_code_addr = '0;
    m_stall     = '0;
    m_q.delete();
  endtask

  task automatic check_outputs();
    chk("mem_req", mem_req, m_req);
    if (m_req) chk("mem_addr", mem_addr, m_fetch);
    chk("code_valid", code_valid, m_q.size() >= 4);
    chk("code_addr", code_addr, m_code_addr);
    chk("align", align, m_code_addr[1:0]);
    if (m_q.size() >= 4) chk("codebuf", codebuf, {m_q[3], m_q[2], m_q[1], m_q[0]});
`ifdef CODE_QUEUE_STATS_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  // One clock: check outputs at the falling edge, drive inputs, advance the model.
  task automatic cyc(input logic f, input logic [31:0] fa, input logic c, input logic [3:0] len);
    logic ack;
    logic cok;
    int   pop;
    check_outputs();
    ack = m_req && ((policy == 1) || ((policy == 2) && ($urandom_range(0, 1) == 1)));
    flush       = f;
    flush_addr  = fa;
    consume     = c;
    consume_len = len;
    mem_ack     = ack;
    mem_data    = ack ? word_at(m_fetch) : $urandom;
    if (ack) acked.push_back(mem_addr);

    if (m_mode == 1 && m_q.size() < 4) m_stall++;
    cok = c && (m_q.size() >= 4) && !f && (len != 4'd0);
    if (f) begin
      case (m_mode)
        0: begin m_mode = 1; m_fetch = {fa[31:2], 2'b00}; m_req = 1'b1; end
        1: begin
          if (m_req && !ack) begin m_mode = 2; m_drain = {fa[31:2], 2'b00}; end
          else begin m_fetch = {fa[31:2], 2'b00}; m_req = 1'b1; end
        end
        default: begin
          m_drain = {fa[31:2], 2'b00};
          if (ack) begin m_mode = 1; m_fetch = m_drain; m_req = 1'b1; end
        end
      endcase
      m_code_addr = fa;
      m_q.delete();
    end else if (m_mode == 2) begin
      if (ack) begin m_mode = 1; m_fetch = m_drain; m_req = 1'b1; end
    end else if (m_mode == 1) begin
      if (cok) begin
        pop = (int'(m_code_addr[1:0]) + int'(len)) / 4;
        for (int i = 0; i < pop; i++) void'(m_q.pop_front());
        m_code_addr = m_code_addr + 32'(len);
      end
      if (m_req) begin
        if (ack) begin
          m_q.push_back(word_at(m_fetch));
          m_fetch = m_fetch + 32'd4;
        end
        m_req = !ack;
      end else begin
        m_req = (m_q.size() < DEPTH);
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    int n;
    logic [31:0] fa;
    reset_n = 1'b0; flush = 1'b0; flush_addr = '0; mem_ack = 1'b0;
    mem_data = '0; consume = 1'b0; consume_len = '0;
    model_reset();
    repeat (2) @(negedge clock);

    // Reset values
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_code_valid", code_valid, 1'b0);
    chk("rst_align", align, 2'd0);
    chk("rst_code_addr", code_addr, 32'h0);
    chk("rst_codebuf", codebuf, 128'h0);
    reset_n = 1'b1;
    cyc(0, 0, 0, 0);

    // Flush to 0x1002, ack everything until the window fills
    policy = 1;
    acked.delete();
    cyc(1, 32'h0000_1002, 0, 0);
    n = 0;
    while (m_q.size() < 4 && n < 40) begin cyc(0, 0, 0, 0); n++; end
    chk("fill_timeout", n < 40, 1'b1);
    chk("fill_cycles", n, 7);
    for (int i = 0; i < 4; i++)
      chk("ack_addr", (acked.size() > i) ? acked[i] : 32'hDEAD_BEEF, 32'h1000 + 32'(4 * i));
    chk("first_valid", code_valid, 1'b1);
    chk("first_align", align, 2'd2);
    chk("first_code_addr", code_addr, 32'h1002);
    chk("first_codebuf", codebuf, 128'h0F0E0D0C_0B0A0908_07060504_03020100);

    // Consume 15 at align 2, then hold the next request and flush under it
    policy = 0;
    cyc(0, 0, 1, 15);
    chk("c15_align", align, 2'd1);
    chk("c15_code_addr", code_addr, 32'h1011);
    chk("c15_valid", code_valid, 1'b0);
    chk("pend_addr", mem_addr, 32'h1010);
    chk("pend_req", mem_req, 1'b1);
    cyc(1, 32'h0000_2000, 0, 0);
    repeat (3) begin
      chk("drain_hold", mem_addr, 32'h1010);
      cyc(0, 0, 0, 0);
    end
    policy = 1;
    cyc(0, 0, 0, 0);
    chk("after_drain_addr", mem_addr, 32'h2000);
    chk("after_drain_req", mem_req, 1'b1);

    // Fill to DEPTH, request must stop; consume 4 at align 0 re-enables it
    n = 0;
    while (!(m_q.size() == DEPTH && !m_req) && n < 60) begin cyc(0, 0, 0, 0); n++; end
    chk("full_timeout", n < 60, 1'b1);
    chk("full_req", mem_req, 1'b0);
    cyc(0, 0, 0, 0);
    chk("full_req_hold", mem_req, 1'b0);
    chk("full_codebuf", codebuf, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    cyc(0, 0, 1, 4);
    chk("refill_req", mem_req, 1'b1);
    chk("refill_code_addr", code_addr, 32'h2004);

    // Ack and consume 5 at align 3 in the same cycle
    cyc(1, 32'h0000_3003, 0, 0);
    n = 0;
    while (!(m_q.size() >= 4 && m_req) && n < 40) begin cyc(0, 0, 0, 0); n++; end
    chk("ackc_timeout", n < 40, 1'b1);
    chk("ackc_pre_align", align, 2'd3);
    cyc(0, 0, 1, 5);
    chk("ackc_align", align, 2'd0);
    chk("ackc_code_addr", code_addr, 32'h3008);
    chk("ackc_valid", code_valid, 1'b0);

    // Address wrap at the top of the 32-bit space
    acked.delete();
    cyc(1, 32'hFFFF_FFF9, 0, 0);
    n = 0;
    while (m_q.size() < 4 && n < 40) begin cyc(0, 0, 0, 0); n++; end
    chk("wrap_timeout", n < 40, 1'b1);
    chk("wrap_ack0", (acked.size() > 0) ? acked[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
    chk("wrap_ack2", (acked.size() > 2) ? acked[2] : 32'hDEAD_BEEF, 32'h0000_0000);
    cyc(0, 0, 1, 15);
    chk("wrap_code_addr", code_addr, 32'h0000_0008);
    chk("wrap_align", align, 2'd0);

    // Randomized traffic
    policy = 2;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        fa = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
        cyc(1, fa, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
      end else begin
        cyc(0, $urandom, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
      end
    end

    // Asynchronous reset while a request is outstanding
    policy = 0;
    cyc(1, 32'h0000_4000, 0, 0);
    chk("arst_pre_req", mem_req, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", mem_req, 1'b0);
    chk("arst_addr", mem_addr, 32'h0);
    chk("arst_codebuf", codebuf, 128'h0);
    model_reset();
    flush = 1'b0; consume = 1'b0; mem_ack = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) cyc(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
